// File: rtl/shared_mem_arb_pkg.sv
// Shared definitions for the shared-memory arbiter: lock FSM states,
// default parameter values and the master-index width helper.
package shared_mem_arb_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  localparam int DEF_NUM_MASTERS  = 4;
  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_LOCK_TIMEOUT = 256;

  function automatic int idx_width(input int num_masters);
    return (num_masters > 1) ? $clog2(num_masters) : 1;
  endfunction

endpackage

// File: rtl/shared_mem_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after
// rr_ptr, scanning upward with wrap-around.
module shared_mem_rr_pick
  import shared_mem_arb_pkg::*;
#(
  parameter  int NUM_MASTERS = DEF_NUM_MASTERS,
  localparam int IW          = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          rr_ptr,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IW-1:0]          grant_idx,
  output logic                   any_grant
);

  localparam int IW1 = IW + 1;

  logic [IW-1:0]          cand_idx    [NUM_MASTERS];
  logic [IW-1:0]          idx_masked  [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] hit;
  logic [NUM_MASTERS-1:0] first_hit;

  // hit[gi] means the master gi positions after rr_ptr is requesting, so the
  // lowest set bit of hit is the round-robin winner.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
      logic [IW1-1:0] sum;
      assign sum = {1'b0, rr_ptr} + IW1'(gi);
      assign cand_idx[gi]   = (sum >= IW1'(NUM_MASTERS)) ? IW'(sum - IW1'(NUM_MASTERS))
                                                         : sum[IW-1:0];
      assign hit[gi]        = req[cand_idx[gi]];
      assign idx_masked[gi] = first_hit[gi] ? cand_idx[gi] : '0;
      assign grant[gi]      = any_grant && (grant_idx == IW'(gi));
    end
  endgenerate

  assign first_hit = hit & (-hit);
  assign any_grant = |hit;

  always_comb begin
    grant_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      grant_idx = grant_idx | idx_masked[k];
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_MASTERS
// Avalon-MM masters, with 1-cycle read return and a timeout-bounded lock.
module shared_mem_arbiter
  import shared_mem_arb_pkg::*;
#(
  parameter int NUM_MASTERS  = DEF_NUM_MASTERS,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
  input  logic [NUM_MASTERS-1:0]          m_read,
  input  logic [NUM_MASTERS-1:0]          m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
  input  logic [NUM_MASTERS-1:0]          m_lock,
  output logic [NUM_MASTERS-1:0]          m_waitrequest,
  output logic [DATA_W-1:0]               m_readdata,
  output logic [NUM_MASTERS-1:0]          m_readdatavalid,
  output logic [ADDR_W-1:0]               mem_address,
  output logic [DATA_W/8-1:0]             mem_byteenable,
  output logic                            mem_chipselect,
  output logic                            mem_write,
  output logic [DATA_W-1:0]               mem_writedata,
  output logic                            mem_clken,
  input  logic [DATA_W-1:0]               mem_readdata,
  output logic [NUM_MASTERS-1:0]          lock_err,
  input  logic                            lock_err_clr
);

  localparam int IW   = idx_width(NUM_MASTERS);
  localparam int BE_W = DATA_W / 8;
  localparam int CW   = $clog2(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

  lock_state_t            state_reg, state_next;
  logic [IW-1:0]          rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]          owner_reg, owner_next;
  logic [CW-1:0]          lock_cnt_reg, lock_cnt_next;
  logic [NUM_MASTERS-1:0] lock_err_reg, lock_err_next;
  logic                   rd_pend_reg;
  logic [IW-1:0]          rd_owner_reg;

  logic [NUM_MASTERS-1:0] req, owner_mask, eligible, grant_raw, grant;
  logic [IW-1:0]          grant_idx;
  logic                   any_raw, accept, accept_read;

  logic [ADDR_W-1:0] addr_arr [NUM_MASTERS];
  logic [BE_W-1:0]   be_arr   [NUM_MASTERS];
  logic [DATA_W-1:0] wd_arr   [NUM_MASTERS];

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IW'(1);
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
      assign addr_arr[gi]        = m_address[gi*ADDR_W +: ADDR_W];
      assign be_arr[gi]          = m_byteenable[gi*BE_W +: BE_W];
      assign wd_arr[gi]          = m_writedata[gi*DATA_W +: DATA_W];
      assign owner_mask[gi]      = (owner_reg == IW'(gi));
      assign m_readdatavalid[gi] = reset_n && rd_pend_reg && (rd_owner_reg == IW'(gi));
    end
  endgenerate

  assign req      = m_read | m_write;
  assign eligible = (state_reg == LOCKED) ? (req & owner_mask) : req;

  shared_mem_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req       (eligible),
    .rr_ptr    (rr_ptr_reg),
    .grant     (grant_raw),
    .grant_idx (grant_idx),
    .any_grant (any_raw)
  );

  // Nothing is accepted while reset is held, even though the inputs may be live.
  assign accept      = any_raw && reset_n;
  assign grant       = accept ? grant_raw : '0;
  assign accept_read = accept && m_read[grant_idx] && !m_write[grant_idx];

  assign m_waitrequest  = ~grant;
  assign m_readdata     = mem_readdata;
  assign mem_chipselect = accept;
  assign mem_write      = accept && m_write[grant_idx];
  assign mem_address    = accept ? addr_arr[grant_idx] : '0;
  assign mem_byteenable = accept ? be_arr[grant_idx]   : '0;
  assign mem_writedata  = accept ? wd_arr[grant_idx]   : '0;
  assign mem_clken      = 1'b1;
  assign lock_err       = lock_err_reg;

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    lock_cnt_next = lock_cnt_reg;
    rr_ptr_next   = rr_ptr_reg;
    lock_err_next = lock_err_reg;
    if (lock_err_clr) lock_err_next = '0;
    if (accept) rr_ptr_next = inc_wrap(grant_idx);
    case (state_reg)
      UNLOCKED: begin
        if (accept && m_lock[grant_idx]) begin
          state_next    = LOCKED;
          owner_next    = grant_idx;
          lock_cnt_next = '0;
        end
      end
      LOCKED: begin
        lock_cnt_next = lock_cnt_reg + CW'(1);
        // The owner either transfers or idles here, so both voluntary
        // release paths reduce to the owner dropping m_lock.
        if (!m_lock[owner_reg]) begin
          state_next    = UNLOCKED;
          lock_cnt_next = '0;
        end else if (lock_cnt_reg == CNT_LAST) begin
          state_next               = UNLOCKED;
          lock_cnt_next            = '0;
          lock_err_next[owner_reg] = 1'b1;
          rr_ptr_next              = inc_wrap(owner_reg);
        end
      end
      default: state_next = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= UNLOCKED;
      owner_reg    <= '0;
      lock_cnt_reg <= '0;
      rr_ptr_reg   <= '0;
      lock_err_reg <= '0;
      rd_pend_reg  <= 1'b0;
      rd_owner_reg <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      lock_cnt_reg <= lock_cnt_next;
      rr_ptr_reg   <= rr_ptr_next;
      lock_err_reg <= lock_err_next;
      rd_pend_reg  <= accept_read;
      rd_owner_reg <= grant_idx;
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: stimulus pushes expected read
// returns into a queue, an independent monitor pops them on readdatavalid.
module tb_shared_mem_arbiter;

  localparam int NM = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int LT = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NM*AW-1:0]  m_address;
  logic [NM*BW-1:0]  m_byteenable;
  logic [NM-1:0]     m_read, m_write, m_lock;
  logic [NM*DW-1:0]  m_writedata;
  logic [NM-1:0]     m_waitrequest, m_readdatavalid, lock_err;
  logic [DW-1:0]     m_readdata;
  logic [AW-1:0]     mem_address;
  logic [BW-1:0]     mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken, lock_err_clr;
  logic [DW-1:0]     mem_writedata;
  logic [DW-1:0]     mem_readdata = '0;

  logic [DW-1:0] mem [0:65535];

  typedef struct {
    logic [NM-1:0] who;
    logic [DW-1:0] data;
    string         tag;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  shared_mem_arbiter #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_address(m_address), .m_byteenable(m_byteenable),
    .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_lock(m_lock), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata),
    .lock_err(lock_err), .lock_err_clr(lock_err_clr)
  );

  always #5 clk = ~clk;

  // Single-port memory with byte enables and 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= mem[mem_address];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
      $display("ok   %s actual=%0h", name, act);
    end else begin
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [NM-1:0] who, input logic [DW-1:0] data, input string tag);
    exp_t e;
    e.who  = who;
    e.data = data;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic set_rd(input int m, input logic [AW-1:0] a, input logic lk);
    m_read[m]            = 1'b1;
    m_address[m*AW +: AW] = a;
    m_lock[m]            = lk;
  endtask

  task automatic set_wr(input int m, input logic [AW-1:0] a, input logic [BW-1:0] be,
                        input logic [DW-1:0] d, input logic lk);
    m_write[m]               = 1'b1;
    m_address[m*AW +: AW]    = a;
    m_byteenable[m*BW +: BW] = be;
    m_writedata[m*DW +: DW]  = d;
    m_lock[m]                = lk;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every readdatavalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (m_readdatavalid != '0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rdv_unexpected actual=%b required=none", m_readdatavalid);
      end else begin
        e = exp_q.pop_front();
        check({e.tag, "_rdv"},  {60'd0, m_readdatavalid}, {60'd0, e.who});
        check({e.tag, "_data"}, {32'd0, m_readdata},      {32'd0, e.data});
      end
    end
  end

  logic [NM-1:0] t1_wr   [NM];
  logic [DW-1:0] t1_data [NM];

  initial begin
    t1_wr   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    t1_data = '{32'h0000_1010, 32'h0000_2020, 32'h0000_3030, 32'h0000_4040};
    mem[16'h0010] = 32'h0000_1010;
    mem[16'h0020] = 32'h0000_2020;
    mem[16'h0030] = 32'h0000_3030;
    mem[16'h0040] = 32'h0000_4040;
    mem[16'h0100] = 32'h1234_5678;
    for (int k = 0; k < 8; k++) mem[16'h0200 + k] = 32'hB200_0000 + k;

    reset_n = 1'b0; m_address = '0; m_byteenable = '0; m_read = '0; m_write = '0;
    m_writedata = '0; m_lock = '0; lock_err_clr = 1'b0;
    for (int i = 0; i < NM; i++) set_rd(i, AW'(16 * (i + 1)), 1'b0);

    // Reset with all masters requesting: nothing may be granted.
    repeat (2) begin
      @(negedge clk);
      check("rst_waitreq", m_waitrequest, 4'hF);
      check("rst_cs_wr",   {mem_chipselect, mem_write}, 2'b00);
      check("rst_rdv",     m_readdatavalid, 4'h0);
      check("rst_clken",   mem_clken, 1'b1);
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
    check("rst_lock_err", lock_err, 4'h0);

    // Four simultaneous reads are served 0,1,2,3.
    for (int k = 0; k < NM; k++) begin
      @(negedge clk);
      check($sformatf("t1_grant%0d", k), m_waitrequest, t1_wr[k]);
      check($sformatf("t1_addr%0d", k), mem_address, AW'(16 * (k + 1)));
      push_exp(NM'(1) << k, t1_data[k], $sformatf("t1_m%0d", k));
      next_cycle();
      m_read[k] = 1'b0;
    end

    // Master 2 streams 8 reads.
    for (int k = 0; k < 8; k++) begin
      set_rd(2, AW'(16'h0200 + k), 1'b0);
      @(negedge clk);
      check($sformatf("t2_wait%0d", k), m_waitrequest, 4'b1011);
      push_exp(4'b0100, 32'hB200_0000 + k, $sformatf("t2_rd%0d", k));
      next_cycle();
    end
    m_read[2] = 1'b0;

    // Partial write then read-back.
    set_wr(1, 16'h0100, 4'h3, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check("t3_wr_grant", m_waitrequest, 4'b1101);
    check("t3_mem_write", {mem_chipselect, mem_write}, 2'b11);
    check("t3_mem_be", mem_byteenable, 4'h3);
    check("t3_mem_wd", mem_writedata, 32'hDEAD_BEEF);
    next_cycle();
    m_write[1] = 1'b0;
    set_rd(3, 16'h0100, 1'b0);
    @(negedge clk);
    check("t3_rd_grant", m_waitrequest, 4'b0111);
    push_exp(4'b1000, 32'h1234_BEEF, "t3_rmw");
    next_cycle();
    m_read[3] = 1'b0;

    // Master 0 lock sequence blocks master 1 until its unlocking write.
    set_rd(0, 16'h0010, 1'b1);
    set_rd(1, 16'h0020, 1'b0);
    @(negedge clk);
    check("t4_lock_grant", m_waitrequest, 4'b1110);
    push_exp(4'b0001, 32'h0000_1010, "t4_lock_rd");
    next_cycle();
    m_read[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("t4_hold%0d", c), m_waitrequest, 4'b1111);
      next_cycle();
    end
    set_wr(0, 16'h0100, 4'hF, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    check("t4_unlock_wr", m_waitrequest, 4'b1110);
    next_cycle();
    m_write[0] = 1'b0;
    @(negedge clk);
    check("t4_m1_next", m_waitrequest, 4'b1101);
    push_exp(4'b0010, 32'h0000_2020, "t4_m1_rd");
    next_cycle();
    m_read[1] = 1'b0;

    // Master 2 holds the lock until the timeout releases it.
    set_rd(2, 16'h0030, 1'b1);
    set_rd(0, 16'h0040, 1'b0);
    @(negedge clk);
    check("t5_lock_grant", m_waitrequest, 4'b1011);
    push_exp(4'b0100, 32'h0000_3030, "t5_lock_rd");
    next_cycle();
    m_read[2] = 1'b0;
    for (int c = 1; c <= LT; c++) begin
      @(negedge clk);
      check($sformatf("t5_hold%0d", c), m_waitrequest, 4'b1111);
      next_cycle();
    end
    set_rd(2, 16'h0030, 1'b0);
    @(negedge clk);
    check("t5_release_m0", m_waitrequest, 4'b1110);
    check("t5_lock_err", lock_err, 4'b0100);
    push_exp(4'b0001, 32'h0000_4040, "t5_m0_rd");
    next_cycle();
    m_read[0] = 1'b0;
    @(negedge clk);
    check("t5_m2_after", m_waitrequest, 4'b1011);
    push_exp(4'b0100, 32'h0000_3030, "t5_m2_rd");
    next_cycle();
    m_read[2] = 1'b0;
    m_lock    = '0;
    lock_err_clr = 1'b1;
    @(negedge clk);
    check("t5_err_held", lock_err, 4'b0100);
    next_cycle();
    lock_err_clr = 1'b0;

    // Read accepted right before reset must never return.
    set_rd(1, 16'h0020, 1'b0);
    @(negedge clk);
    check("t5_err_clr", lock_err, 4'h0);
    check("t6_m1_grant", m_waitrequest, 4'b1101);
    next_cycle();
    reset_n = 1'b0;
    for (int i = 0; i < NM; i++) set_rd(i, AW'(16 * (i + 1)), 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("t6_rst_rdv", m_readdatavalid, 4'h0);
      check("t6_rst_wait", m_waitrequest, 4'hF);
      next_cycle();
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("t6_post_rst_m0", m_waitrequest, 4'b1110);
    push_exp(4'b0001, 32'h0000_1010, "t6_m0_rd");
    next_cycle();
    m_read = '0;
    repeat (3) next_cycle();
    check("end_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
Shares the single-port 64K x 32 on-chip shared memory between NUM_MASTERS processor data masters in the MPSoC. Round-robin arbitration grants one transfer per cycle. The block routes the 1-cycle read data back to the issuing master. An optional per-master lock holds the grant across read-modify-write sequences and is bounded by a timeout. It sits between the per-CPU Avalon-MM master ports and the memory slave port.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
ADDR_W, 16, word address width (matches memory depth 65536)
DATA_W, 32, data width; byteenable width is DATA_W/8
LOCK_TIMEOUT, 256, max consecutive cycles one master may hold the lock (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
m_address  in  NUM_MASTERS*ADDR_W  packed per-master word addresses, master i at slice i
m_byteenable  in  NUM_MASTERS*DATA_W/8  packed byte enables
m_read  in  NUM_MASTERS  read request per master
m_write  in  NUM_MASTERS  write request per master
m_writedata  in  NUM_MASTERS*DATA_W  packed write data
m_lock  in  NUM_MASTERS  request to hold the grant after this transfer
m_waitrequest  out  NUM_MASTERS  1 = request not accepted this cycle
m_readdata  out  DATA_W  broadcast read data
m_readdatavalid  out  NUM_MASTERS  one-hot, marks the owner of m_readdata
mem_address  out  ADDR_W  to memory
mem_byteenable  out  DATA_W/8  to memory
mem_chipselect  out  1  to memory
mem_write  out  1  to memory
mem_writedata  out  DATA_W  to memory
mem_clken  out  1  tied 1 (reset_req driven 0 at top level)
mem_readdata  in  DATA_W  from memory, valid 1 cycle after a read is accepted
lock_err  out  NUM_MASTERS  sticky per-master flag: lock timed out
lock_err_clr  in  1  clears all of lock_err

Behaviour:
- Request for master i: req[i] = m_read[i] | m_write[i]. If both are high, the write is performed and the read is ignored (no readdatavalid).
- Grant is combinational within the cycle. Among eligible requesters, pick the first at or after rr_ptr, scanning upward and wrapping.
- Granted master: m_waitrequest=0, and its transfer is accepted this cycle. All other masters: m_waitrequest=1.
- Memory drive when a grant exists: mem_chipselect=1, mem_write=m_write[g], and address/byteenable/writedata from slice g.
- Memory drive with no grant: mem_chipselect=0, mem_write=0, data buses 0.
- After each accepted transfer, rr_ptr <= (g+1) mod NUM_MASTERS. rr_ptr does not change on idle cycles.
- Read return: an accepted read registers rd_pend=1 and rd_owner=g. In the next cycle, m_readdatavalid[rd_owner]=1 and m_readdata=mem_readdata.
- A master may issue back-to-back reads; one accept per cycle gives a fully pipelined throughput of 1. Writes produce no response.
- Lock FSM states:
  - UNLOCKED: all requesters are eligible. An accepted transfer with m_lock[g]=1 moves to LOCKED with owner=g and lock_cnt=0.
  - LOCKED: only the owner is eligible, and lock_cnt increments every cycle.
  - Leave LOCKED for UNLOCKED when (a) the owner has an accepted transfer with m_lock=0, or (b) m_lock[owner]=0 while the owner has no request.
  - Also leave LOCKED for UNLOCKED when (c) lock_cnt reaches LOCK_TIMEOUT-1; this also sets lock_err[owner]=1.
  - On a timeout release, rr_ptr <= owner+1 so the hog is not granted first.
  - While locked, a timeout release takes effect the following cycle, and that cycle's owner transfer is still honoured.
- lock_err bits stay set until lock_err_clr=1. A set condition and a clear in the same cycle resolve to set.
- Reset (reset_n=0 at a clk edge):
  - rr_ptr=0, state UNLOCKED, rd_pend=0, lock_err=0, lock_cnt=0.
  - Outputs while reset_n=0: m_waitrequest all 1, m_readdatavalid 0, mem_chipselect 0, mem_write 0.
  - A read accepted just before reset produces no readdatavalid.
- mem_clken is constantly 1, and the memory read latency is fixed at 1. No internal buffering is needed beyond rd_pend/rd_owner.

Decomposition:
- Package shared_mem_arb_pkg: lock FSM state enum (UNLOCKED, LOCKED), default parameter constants, and a function for the master-index width, $clog2(NUM_MASTERS).
- Sub-module shared_mem_rr_pick: combinational round-robin picker. Inputs: eligible-request vector and rr_ptr. Outputs: one-hot grant, grant index, any_grant.
- The top level holds rr_ptr, the lock FSM, lock_cnt, the read-return register, lock_err and the muxing.

Test Plan:
- After reset, all four masters read simultaneously with addresses 0x10,0x20,0x30,0x40. Required: grants in order 0,1,2,3 on consecutive cycles; readdatavalid arrives one cycle later for each, carrying the preloaded words.
- Master 2 alone issues 8 back-to-back reads. Required: waitrequest stays 0 throughout and readdatavalid[2] is high for 8 consecutive cycles with the matching data.
- Master 1 writes 0xDEADBEEF to 0x100 with byteenable 0x3, then master 3 reads 0x100. Required: the low 16 bits read 0xBEEF and the upper half is unchanged.
- Master 0 does a locked read with m_lock=1 then writes 0x100 with m_lock=0, while master 1 requests continuously. Required: master 1 waitrequest=1 until master 0's write is accepted, then master 1 is granted next.
- With LOCK_TIMEOUT=16, master 2 locks and holds m_lock=1 while master 0 requests. Required: release after 16 cycles, lock_err=4'b0100, master 0 granted next; lock_err_clr returns lock_err to 0.
- Master 1 read accepted, then reset_n=0 on the following edge. Required: no readdatavalid, all waitrequest=1, and rr_ptr=0 afterwards, so master 0 wins the first post-reset contention.
